// File: rtl/nibble_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_packer_pkg
//  Description : Shared constants and FSM state type for the nibble packer.
//                NIBBLE_W    - width of one input sample
//                DEF_NIBBLES - default samples per output word
//                DEF_DEPTH   - default output FIFO depth (words)
//  Revision    : 1.0 - initial release
// ============================================================================
package nibble_packer_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int DEF_NIBBLES = 4;
  localparam int DEF_DEPTH   = 2;

  // EMPTY: no nibbles held; FILL: 1..NIBBLES-1 nibbles held
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FILL  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/nibble_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_packer_if
//  Description : Sample-in / word-out bundle of the nibble packer.
//                data, data_valid, flush       - upstream sample side
//                word, word_count, word_valid,
//                word_ready                    - downstream word handshake
//                overflow                      - sticky word-drop flag
//                master : drives samples, consumes words
//                slave  : the packer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface nibble_packer_if
  import nibble_packer_pkg::*;
#(
  parameter int NIBBLES = DEF_NIBBLES
) ();

  localparam int WORD_W = NIBBLE_W * NIBBLES;
  localparam int CNT_W  = $clog2(NIBBLES + 1);

  logic [NIBBLE_W-1:0] data;
  logic                data_valid;
  logic                flush;
  logic [WORD_W-1:0]   word;
  logic [CNT_W-1:0]    word_count;
  logic                word_valid;
  logic                word_ready;
  logic                overflow;

  modport master (
    output data, data_valid, flush, word_ready,
    input  word, word_count, word_valid, overflow
  );

  modport slave (
    input  data, data_valid, flush, word_ready,
    output word, word_count, word_valid, overflow
  );

endinterface
`default_nettype wire

// File: rtl/nibble_packer_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : word_fifo
//  Description : Registered FIFO of packed {word_count, word} entries.
//                clock, clear_n  - clock and async active-low reset
//                push_i/push_data_i - write request and entry
//                pop_i           - read request (head advances)
//                pop_data_o      - head entry, zero while empty
//                full_o, empty_o, count_o - occupancy status
//                A push on a full FIFO is only written when a pop frees the
//                head slot on the same edge; otherwise it is discarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module word_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 2
) (
  input  wire logic                       clock,
  input  wire logic                       clear_n,
  input  wire logic                       push_i,
  input  wire logic [WIDTH-1:0]           push_data_i,
  input  wire logic                       pop_i,
  output logic      [WIDTH-1:0]           pop_data_o,
  output logic                            full_o,
  output logic                            empty_o,
  output logic      [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             do_write, do_read;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == OCC_W'(DEPTH));
  assign count_o  = count_q;
  assign do_read  = pop_i && !empty_o;
  assign do_write = push_i && (!full_o || do_read);

  // Head is read straight from storage; a word pushed this edge appears
  // only after the edge, so there is no push-to-pop bypass.
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_write) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_read) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_write, do_read})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nibble_packer.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_packer
//  Description : Packs 4-bit samples LSB-first into NIBBLES-wide words and
//                queues them in a DEPTH-entry output FIFO.
//                clock   - rising-edge clock
//                clear_n - asynchronous active-low reset
//                bus     - nibble_packer_if slave: sample input, word
//                          handshake output and sticky overflow flag
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int NIBBLES = DEF_NIBBLES,
  parameter int DEPTH   = DEF_DEPTH
) (
  input wire logic        clock,
  input wire logic        clear_n,
  nibble_packer_if.slave  bus
);

  localparam int WORD_W  = NIBBLE_W * NIBBLES;
  localparam int CNT_W   = $clog2(NIBBLES + 1);
  localparam int ENTRY_W = CNT_W + WORD_W;
  localparam int OCC_W   = $clog2(DEPTH + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic                overflow_q, overflow_d;

  logic [WORD_W-1:0]   acc_next;
  logic [CNT_W-1:0]    cnt_next;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [OCC_W-1:0]    fifo_count;
  logic [ENTRY_W-1:0]  fifo_head;

  always_comb begin
    acc_next   = acc_q;
    cnt_next   = count_q;
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    push       = 1'b0;

    // The incoming nibble is merged before the push decision so that a
    // flush on the same edge emits a word that already contains it.
    if (bus.data_valid) begin
      for (int k = 0; k < NIBBLES; k++) begin
        if (count_q == CNT_W'(k)) begin
          acc_next[k*NIBBLE_W +: NIBBLE_W] = bus.data;
        end
      end
      cnt_next = count_q + CNT_W'(1);
    end

    push = (cnt_next == CNT_W'(NIBBLES)) ||
           (bus.flush && ((state_q == ST_FILL) || bus.data_valid));

    if (push) begin
      // Cleared even when the FIFO drops the word.
      acc_d   = '0;
      count_d = '0;
      state_d = ST_EMPTY;
    end else begin
      acc_d   = acc_next;
      count_d = cnt_next;
      state_d = (cnt_next == '0) ? ST_EMPTY : ST_FILL;
    end
  end

  assign pop        = bus.word_ready && (fifo_count != '0);
  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q    <= ST_EMPTY;
      count_q    <= '0;
      acc_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      overflow_q <= overflow_d;
    end
  end

  word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_word_fifo (
    .clock       (clock),
    .clear_n     (clear_n),
    .push_i      (push),
    .push_data_i ({cnt_next, acc_next}),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign bus.word       = fifo_head[WORD_W-1:0];
  assign bus.word_count = fifo_head[WORD_W +: CNT_W];
  assign bus.word_valid = !fifo_empty;
  assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_packer
//  Description : Self-checking bench for nibble_packer (NIBBLES=4, DEPTH=2).
//                Expected words are queued as stimulus is driven and popped
//                whenever the DUT transfers a word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_packer;
  import nibble_packer_pkg::*;

  typedef struct packed {
    logic [2:0]  cnt;
    logic [15:0] w;
  } exp_t;

  logic clock   = 1'b0;
  logic clear_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  nibble_packer_if #(.NIBBLES(4)) bus ();

  nibble_packer #(
    .NIBBLES (4),
    .DEPTH   (2)
  ) dut (
    .clock   (clock),
    .clear_n (clear_n),
    .bus     (bus.slave)
  );

  // Scoreboard: a word seen valid+ready at negedge transfers on the next
  // rising edge, so it is compared here.
  always @(negedge clock) begin
    exp_t e;
    if (clear_n && bus.word_valid && bus.word_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got word=%h count=%0d, required no word",
                 bus.word, bus.word_count);
      end else begin
        e = sb.pop_front();
        if (bus.word !== e.w || bus.word_count !== e.cnt) begin
          n_fail++;
          $display("FAIL sb_word: got word=%h count=%0d, required word=%h count=%0d",
                   bus.word, bus.word_count, e.w, e.cnt);
        end
      end
    end
  end

  task automatic send(input logic [3:0] d, input logic fl);
    bus.data       = d;
    bus.data_valid = 1'b1;
    bus.flush      = fl;
    @(posedge clock);
    #1;
    bus.data_valid = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic test_reset;
    #1 clear_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (bus.word_valid !== 1'b0 || bus.word !== 16'h0 ||
        bus.word_count !== 3'd0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b word=%h cnt=%0d ovf=%b, required all 0",
               bus.word_valid, bus.word, bus.word_count, bus.overflow);
    end
    clear_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_single;
    bus.word_ready = 1'b1;
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    n_checks++;
    if (bus.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: got valid=%b, required 0", bus.word_valid);
    end
    sb.push_back('{3'd4, 16'h4321});
    send(4'h4, 1'b0);
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.word !== 16'h4321) begin
      n_fail++;
      $display("FAIL single_latency: got valid=%b word=%h, required 1 4321",
               bus.word_valid, bus.word);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (bus.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: got valid=%b, required 0", bus.word_valid);
    end
  endtask

  task automatic test_flush;
    bus.word_ready = 1'b1;
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    sb.push_back('{3'd2, 16'h00BA});
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.word_count !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_partial: got valid=%b cnt=%0d, required 1 2",
               bus.word_valid, bus.word_count);
    end
    @(posedge clock);
    #1;
    bus.flush = 1'b1;
    @(posedge clock);
    #1;
    bus.flush = 1'b0;
    n_checks++;
    if (bus.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_empty: got valid=%b, required 0", bus.word_valid);
    end
  endtask

  task automatic test_flush_with_data;
    bus.word_ready = 1'b1;
    send(4'h3, 1'b0);
    sb.push_back('{3'd2, 16'h00C3});
    send(4'hC, 1'b1);
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.word !== 16'h00C3) begin
      n_fail++;
      $display("FAIL flush_data: got valid=%b word=%h, required 1 00C3",
               bus.word_valid, bus.word);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL flush_data_drain: got %0d pending, required 0", sb.size());
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_full_pop_push;
    bus.word_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) sb.push_back('{3'd4, 16'h4321});
      if (i == 8) sb.push_back('{3'd4, 16'h8765});
      send(4'(i), 1'b0);
    end
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.word !== 16'h4321 || bus.word_count !== 3'd4) begin
      n_fail++;
      $display("FAIL full_hold: got valid=%b word=%h cnt=%0d, required 1 4321 4",
               bus.word_valid, bus.word, bus.word_count);
    end
    send(4'h9, 1'b0);
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    sb.push_back('{3'd4, 16'hCBA9});
    bus.word_ready = 1'b1;
    send(4'hC, 1'b0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain: got %0d pending, required 0", sb.size());
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_no_overflow: got ovf=%b, required 0", bus.overflow);
    end
  endtask

  task automatic test_overflow;
    bus.word_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) sb.push_back('{3'd4, 16'h3210});
      if (i == 7) sb.push_back('{3'd4, 16'h7654});
      send(4'(i), 1'b0);
      if (i == 7) begin
        n_checks++;
        if (bus.overflow !== 1'b0) begin
          n_fail++;
          $display("FAIL ovf_early: got ovf=%b, required 0", bus.overflow);
        end
      end
    end
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.word !== 16'h3210 || bus.word_count !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_set: got ovf=%b word=%h cnt=%0d, required 1 3210 4",
               bus.overflow, bus.word, bus.word_count);
    end
    bus.word_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL ovf_drain: got %0d pending, required 0", sb.size());
    end
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (bus.overflow !== 1'b1 || bus.word_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_sticky: got ovf=%b valid=%b, required 1 0",
               bus.overflow, bus.word_valid);
    end
  endtask

  task automatic test_reset_mid_fill;
    bus.word_ready = 1'b1;
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    #3 clear_n = 1'b0;
    #1;
    n_checks++;
    if (bus.word_valid !== 1'b0 || bus.word !== 16'h0 ||
        bus.word_count !== 3'd0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got valid=%b word=%h cnt=%0d ovf=%b, required all 0",
               bus.word_valid, bus.word, bus.word_count, bus.overflow);
    end
    @(negedge clock);
    clear_n = 1'b1;
    @(posedge clock);
    #1;
    sb.push_back('{3'd4, 16'h4321});
    for (int i = 1; i <= 4; i++) send(4'(i), 1'b0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_refill_drain: got %0d pending, required 0", sb.size());
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bus.data       = 4'h0;
    bus.data_valid = 1'b0;
    bus.flush      = 1'b0;
    bus.word_ready = 1'b0;
    test_reset();
    test_single();
    test_flush();
    test_flush_with_data();
    test_full_pop_push();
    test_overflow();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
